// File: rtl/reg_user_pkg.sv
// Shared types and sizes for the user-register byte loader.
package reg_user_pkg;
  localparam int REG_USER_W     = 64;
  localparam int BYTE_W         = 8;
  localparam int REG_USER_BYTES = 8;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;
endpackage

// File: rtl/strobe_edge.sv
// Rising-edge detector for a level strobe.
// When REG_USER_LOADER_SYNC_EN is defined, a 2-flop synchronizer precedes the edge register.
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic evt
);
  logic level;
  logic level_q;

`ifdef REG_USER_LOADER_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], strobe};
  end
  assign level = sync[1];
`else
  assign level = strobe;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign evt = level & ~level_q;
endmodule

// File: rtl/reg_user_loader.sv
// Byte-serial loader for the 64-bit user register: collects eight bytes, then pulses E with the word.
// Optional input synchronizers are enabled by defining REG_USER_LOADER_SYNC_EN.
module reg_user_loader
  import reg_user_pkg::*;
#(
  parameter int AUTO_COMMIT = 0
) (
  input  logic                  CLK,
  input  logic                  R,
  input  logic [BYTE_W-1:0]     byte_in,
  input  logic                  push,
  input  logic                  commit,
  input  logic                  clear,
  output logic [REG_USER_W-1:0] data,
  output logic                  E,
  output logic [CNT_W-1:0]      byte_cnt,
  output logic                  full,
  output logic                  overflow
);
  logic push_evt;
  logic commit_evt;
  logic clear_evt;

  state_t                state;
  logic [REG_USER_W-1:0] shadow;
  logic [REG_USER_W-1:0] shadow_push;

  strobe_edge u_push_edge   (.clk(CLK), .rst(R), .strobe(push),   .evt(push_evt));
  strobe_edge u_commit_edge (.clk(CLK), .rst(R), .strobe(commit), .evt(commit_evt));
  strobe_edge u_clear_edge  (.clk(CLK), .rst(R), .strobe(clear),  .evt(clear_evt));

  // Shadow with the incoming byte merged into the lane selected by the current count.
  genvar gi;
  generate
    for (gi = 0; gi < REG_USER_BYTES; gi++) begin : g_lane
      assign shadow_push[gi*BYTE_W +: BYTE_W] =
        (byte_cnt[2:0] == 3'(gi)) ? byte_in : shadow[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  assign full = (byte_cnt == CNT_W'(REG_USER_BYTES));

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state    <= IDLE;
      shadow   <= '0;
      byte_cnt <= '0;
      data     <= '0;
      E        <= 1'b0;
      overflow <= 1'b0;
    end else begin
      E <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (clear_evt) begin
            shadow   <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
          end else if (commit_evt && state == COLLECT) begin
            data  <= shadow;
            E     <= 1'b1;
            state <= COMMIT;
          end else if (push_evt) begin
            if (!full) begin
              shadow   <= shadow_push;
              byte_cnt <= byte_cnt + 4'd1;
              if (AUTO_COMMIT != 0 && byte_cnt == 4'd7) begin
                data  <= shadow_push;
                E     <= 1'b1;
                state <= COMMIT;
              end else begin
                state <= COLLECT;
              end
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        COMMIT: begin
          // Events are ignored here; the word has been handed off, so start fresh.
          shadow   <= '0;
          byte_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_user_loader.sv
// Scoreboard bench for reg_user_loader: a manual-commit instance and an AUTO_COMMIT=1 instance.
module tb_reg_user_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        push, commit, clear;
  logic        push_a, commit_a, clear_a;

  logic [63:0] data,     data_a;
  logic        e,        e_a;
  logic [3:0]  byte_cnt, byte_cnt_a;
  logic        full,     full_a;
  logic        overflow, overflow_a;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          e_seen   = 0;
  int          e_a_seen = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_a_q[$];

  always #10 clk = ~clk;

  reg_user_loader #(.AUTO_COMMIT(0)) dut (
    .CLK(clk), .R(rst), .byte_in(byte_in), .push(push), .commit(commit), .clear(clear),
    .data(data), .E(e), .byte_cnt(byte_cnt), .full(full), .overflow(overflow)
  );

  reg_user_loader #(.AUTO_COMMIT(1)) dut_a (
    .CLK(clk), .R(rst), .byte_in(byte_in), .push(push_a), .commit(commit_a), .clear(clear_a),
    .data(data_a), .E(e_a), .byte_cnt(byte_cnt_a), .full(full_a), .overflow(overflow_a)
  );

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Every E pulse must match the next queued word; a second E cycle finds an empty queue.
  always @(negedge clk) begin
    if (e === 1'b1) begin
      e_seen++;
      chk_eq("sb_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [63:0] w;
        w = exp_q.pop_front();
        $display("commit observed data=%h expected=%h", data, w);
        chk_eq("commit_data", data, w);
      end
    end
    if (e_a === 1'b1) begin
      e_a_seen++;
      chk_eq("sb_a_pending", 64'(exp_a_q.size() > 0), 64'd1);
      if (exp_a_q.size() > 0) begin
        logic [63:0] w;
        w = exp_a_q.pop_front();
        $display("auto commit observed data=%h expected=%h", data_a, w);
        chk_eq("auto_commit_data", data_a, w);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk); byte_in = b; push = 1'b1;
    @(negedge clk); push = 1'b0;
  endtask

  task automatic push_byte_a(input logic [7:0] b);
    @(negedge clk); byte_in = b; push_a = 1'b1;
    @(negedge clk); push_a = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int e_before;
    logic [7:0] b;
    rst = 1'b1; byte_in = '0;
    push = 0; commit = 0; clear = 0; push_a = 0; commit_a = 0; clear_a = 0;
    repeat (3) @(negedge clk);
    chk_eq("rst_data", data, 64'd0);
    chk_eq("rst_e", 64'(e), 64'd0);
    chk_eq("rst_cnt", 64'(byte_cnt), 64'd0);
    chk_eq("rst_full", 64'(full), 64'd0);
    chk_eq("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    // Full word 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      b = 8'h11 * 8'(i + 1);
      push_byte(b);
    end
    chk_eq("full_cnt", 64'(byte_cnt), 64'd8);
    chk_eq("full_flag", 64'(full), 64'd1);
    exp_q.push_back(64'h8877665544332211);
    do_commit();
    chk_eq("post_commit_cnt", 64'(byte_cnt), 64'd0);
    chk_eq("post_commit_hold", data, 64'h8877665544332211);

    // Partial word
    push_byte(8'h40);
    push_byte(8'h03);
    exp_q.push_back(64'h0000000000000340);
    do_commit();
    chk_eq("partial_cnt", 64'(byte_cnt), 64'd0);

    // Commit with nothing captured
    e_before = e_seen;
    do_commit();
    chk_eq("idle_commit_no_e", 64'(e_seen - e_before), 64'd0);
    chk_eq("idle_commit_data", data, 64'h0000000000000340);

    // Nine pushes: overflow, shadow untouched by the ninth
    for (int i = 1; i <= 9; i++) begin
      push_byte(8'(i));
      if (i == 8) chk_eq("ovf_full8", 64'(full), 64'd1);
      if (i == 8) chk_eq("ovf_clear8", 64'(overflow), 64'd0);
    end
    chk_eq("ovf_set", 64'(overflow), 64'd1);
    chk_eq("ovf_cnt", 64'(byte_cnt), 64'd8);
    exp_q.push_back(64'h0807060504030201);
    do_commit();
    chk_eq("ovf_sticky", 64'(overflow), 64'd1);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk_eq("clr_ovf", 64'(overflow), 64'd0);
    chk_eq("clr_cnt", 64'(byte_cnt), 64'd0);
    chk_eq("clr_full", 64'(full), 64'd0);

    // push+commit+clear together: clear wins
    push_byte(8'hB1); push_byte(8'hB2); push_byte(8'hB3);
    e_before = e_seen;
    @(negedge clk); byte_in = 8'hFF; push = 1; commit = 1; clear = 1;
    @(negedge clk); push = 0; commit = 0; clear = 0;
    @(negedge clk);
    chk_eq("triple_cnt", 64'(byte_cnt), 64'd0);
    chk_eq("triple_no_e", 64'(e_seen - e_before), 64'd0);

    // push+commit together: commit of the three old bytes only
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    exp_q.push_back(64'h0000000000A3A2A1);
    @(negedge clk); byte_in = 8'hFF; push = 1; commit = 1;
    @(negedge clk); push = 0; commit = 0;
    @(negedge clk);
    chk_eq("pc_cnt", 64'(byte_cnt), 64'd0);
    chk_eq("pc_ovf", 64'(overflow), 64'd0);

    // Reset during the E cycle
    push_byte(8'h5A);
    @(negedge clk); commit = 1'b1;
    @(posedge clk); #2;
    chk_eq("mid_e_high", 64'(e), 64'd1);
    rst = 1'b1; #1;
    chk_eq("mid_rst_e", 64'(e), 64'd0);
    chk_eq("mid_rst_data", data, 64'd0);
    chk_eq("mid_rst_cnt", 64'(byte_cnt), 64'd0);
    chk_eq("mid_rst_full", 64'(full), 64'd0);
    chk_eq("mid_rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk); commit = 1'b0;
    @(negedge clk); rst = 1'b0;

    // AUTO_COMMIT instance: eighth push commits without a commit strobe
    for (int i = 0; i < 8; i++) begin
      b = 8'hC1 + 8'(i);
      if (i == 7) exp_a_q.push_back(64'hC8C7C6C5C4C3C2C1);
      push_byte_a(b);
      if (i == 6) chk_eq("auto_cnt7", 64'(byte_cnt_a), 64'd7);
    end
    @(negedge clk);
    chk_eq("auto_e_count", 64'(e_a_seen), 64'd1);
    chk_eq("auto_cnt0", 64'(byte_cnt_a), 64'd0);
    chk_eq("auto_hold", data_a, 64'hC8C7C6C5C4C3C2C1);

    repeat (3) @(negedge clk);
    chk_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    chk_eq("sb_a_empty", 64'(exp_a_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
